// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - shares a byte-wide data memory between instruction fetch and load/store
// Each access is split into 1/2/4 big-endian byte beats; reads are assembled and extended.
module dmem_access_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [1:0]        ls_size,
  input  logic              ls_se,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic              is_ls_q, is_ls_d;
  logic              rw_q, rw_d;
  logic              se_q, se_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       shift_q, shift_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              grant_if;
  logic [1:0]        last_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_ext;

  always_comb begin
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // The final beat's byte is still on mem_rdata, so assembly includes it directly.
  always_comb begin
    rd_word = {shift_q[23:0], mem_rdata};
    case (size_q)
      2'b00:   rd_ext = {{24{se_q & rd_word[7]}}, rd_word[7:0]};
      2'b01:   rd_ext = {{16{se_q & rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_ls_d    = is_ls_q;
    rw_d       = rw_q;
    se_d       = se_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    shift_d    = shift_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    grant_if   = if_req && (!ls_req || (starve_q == SW'(STARVE_LIMIT)));

    case (state_q)
      S_IDLE: begin
        if (if_req || ls_req) begin
          is_ls_d = !grant_if;
          if (grant_if) begin
            rw_d    = 1'b0;
            se_d    = 1'b0;
            size_d  = 2'b10;
            addr_d  = if_addr;
            wdata_d = '0;
          end else begin
            rw_d    = ls_rw;
            se_d    = ls_se;
            size_d  = ls_size;
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
          end
          beat_d  = 2'd0;
          shift_d = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        shift_d = rd_word;
        if (beat_q == last_idx) begin
          state_d = S_DONE;
          if (!rw_q) begin
            if (is_ls_q) ls_rdata_d = rd_ext;
            else         if_rdata_d = rd_ext;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Count LS wins while IF waits; the counter is only meaningful while IF is pending.
    if (!if_req) begin
      starve_d = '0;
    end else if (state_q == S_IDLE) begin
      if (grant_if)
        starve_d = '0;
      else if (ls_req && (starve_q != SW'(STARVE_LIMIT)))
        starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      is_ls_q    <= 1'b0;
      rw_q       <= 1'b0;
      se_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat_q     <= 2'd0;
      shift_q    <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      is_ls_q    <= is_ls_d;
      rw_q       <= rw_d;
      se_q       <= se_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign byte_idx  = last_idx - beat_q;
  assign mem_en    = (state_q == S_XFER);
  assign mem_we    = mem_en && rw_q;
  assign mem_addr  = mem_en ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign mem_wdata = mem_we ? 8'(wdata_q >> {byte_idx, 3'b000}) : 8'h00;
  assign if_ready  = (state_q == S_DONE) && !is_ls_q;
  assign ls_ready  = (state_q == S_DONE) && is_ls_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule
